// File: rtl/seg_serial_shifter_if.sv
// Handshake and pin bundle between the display controller and one segment shift engine.
interface seg_serial_shifter_if #(
    parameter int NBITS = 64
);
    logic             start;
    logic [NBITS-1:0] seg_txt;
    logic             busy;
    logic             done;
    logic             seg_clk;
    logic             seg_sout;
    logic             seg_pen;
    logic             seg_clrn;

    modport master (
        output start, seg_txt,
        input  busy, done, seg_clk, seg_sout, seg_pen, seg_clrn
    );

    modport slave (
        input  start, seg_txt,
        output busy, done, seg_clk, seg_sout, seg_pen, seg_clrn
    );
endinterface

// File: rtl/seg_serial_shifter.sv
// Serialises a segment image into a 74HC595-style chain, then pulses the latch.
// Optional SEG_AUTO_REFRESH_EN: start is ignored and frames repeat back to back.
module seg_serial_shifter #(
    parameter int NBITS = 64,
    parameter int HALF  = 2,
    parameter int CW    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    seg_serial_shifter_if.slave  bus
);
    localparam int DW = (HALF > 1) ? $clog2(HALF) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;

    state_t           state_q, state_d;
    // seg_sout_q holds the current MSB; sr_q holds the bits still to go
    logic [NBITS-2:0] sr_q, sr_d;
    logic [CW-1:0]    bitcnt_q, bitcnt_d;
    logic [DW-1:0]    divcnt_q, divcnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             seg_clk_q, seg_clk_d;
    logic             seg_sout_q, seg_sout_d;
    logic             seg_pen_q, seg_pen_d;
    logic             seg_clrn_q, seg_clrn_d;
    logic             start_eff;
    logic             div_end;

`ifdef SEG_AUTO_REFRESH_EN
    logic unused_start;
    assign unused_start = bus.start;
    assign start_eff    = 1'b1;
`else
    assign start_eff    = bus.start;
`endif

    assign div_end = (divcnt_q == DW'(HALF - 1));

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        bitcnt_d   = bitcnt_q;
        divcnt_d   = divcnt_q;
        seg_sout_d = seg_sout_q;
        case (state_q)
            IDLE: begin
                seg_sout_d = 1'b0;
                if (start_eff) begin
                    sr_d       = bus.seg_txt[NBITS-2:0];
                    seg_sout_d = bus.seg_txt[NBITS-1];
                    bitcnt_d   = '0;
                    divcnt_d   = '0;
                    state_d    = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (div_end) begin
                    divcnt_d = '0;
                    state_d  = SHIFT_HI;
                end else begin
                    divcnt_d = divcnt_q + 1'b1;
                end
            end
            SHIFT_HI: begin
                if (div_end) begin
                    divcnt_d   = '0;
                    seg_sout_d = sr_q[NBITS-2];
                    sr_d       = {sr_q[NBITS-3:0], 1'b0};
                    bitcnt_d   = bitcnt_q + 1'b1;
                    state_d    = (bitcnt_q == CW'(NBITS - 1)) ? LATCH : SHIFT_LO;
                end else begin
                    divcnt_d = divcnt_q + 1'b1;
                end
            end
            LATCH: begin
                if (div_end) begin
                    divcnt_d   = '0;
                    seg_sout_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    divcnt_d = divcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs follow the next state so they are registered yet aligned with it
        busy_d     = (state_d != IDLE);
        seg_clk_d  = (state_d == SHIFT_HI);
        seg_pen_d  = (state_d == LATCH);
        done_d     = (state_q == LATCH) && (state_d == IDLE);
        seg_clrn_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            bitcnt_q   <= '0;
            divcnt_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            seg_clk_q  <= 1'b0;
            seg_sout_q <= 1'b0;
            seg_pen_q  <= 1'b0;
            seg_clrn_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bitcnt_q   <= bitcnt_d;
            divcnt_q   <= divcnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            seg_clk_q  <= seg_clk_d;
            seg_sout_q <= seg_sout_d;
            seg_pen_q  <= seg_pen_d;
            seg_clrn_q <= seg_clrn_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.seg_clk  = seg_clk_q;
    assign bus.seg_sout = seg_sout_q;
    assign bus.seg_pen  = seg_pen_q;
    assign bus.seg_clrn = seg_clrn_q;
endmodule

// File: tb/tb_seg_serial_shifter.sv
// Scoreboard bench: frames queued at acceptance, checked by a model 74HC595 chain.
module tb_seg_serial_shifter;
    localparam int NBITS    = 64;
    localparam int HALF     = 2;
    localparam int CW       = 8;
    localparam int BUSY_LEN = NBITS * 2 * HALF + HALF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_serial_shifter_if #(.NBITS(NBITS)) bus ();

    seg_serial_shifter #(.NBITS(NBITS), .HALF(HALF), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [NBITS-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [NBITS-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Model of the external chain: shifts on seg_clk rise, latches on seg_pen rise
    logic [NBITS-1:0] chain, latched;
    int  edges, busy_cnt, pen_cnt, since_done;
    bit  pen_bad, sout_bad, seen_done;
    logic prev_clk, prev_sout, prev_pen, prev_busy, prev_done;

    always @(negedge clk) begin
        if (rst) begin
            chain = '0; latched = '0; edges = 0; busy_cnt = 0; pen_cnt = 0;
            pen_bad = 0; sout_bad = 0; seen_done = 0; since_done = 0;
            prev_clk = 0; prev_sout = 0; prev_pen = 0; prev_busy = 0; prev_done = 0;
        end else begin
            since_done++;
            if (bus.seg_clk && !prev_clk) begin
                chain = {chain[NBITS-2:0], bus.seg_sout};
                edges++;
                if (bus.seg_sout !== prev_sout) sout_bad = 1;
            end
            if (bus.busy) busy_cnt++;
            if (bus.seg_pen) begin
                pen_cnt++;
                if (bus.seg_clk) pen_bad = 1;
                if (!prev_pen) latched = chain;
            end
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    chk("frame_data", latched, exp_q.pop_front());
                    chk("busy_len", 64'(busy_cnt), 64'(BUSY_LEN));
                    chk("clk_edges", 64'(edges), 64'(NBITS));
                    chk("pen_len", 64'(pen_cnt), 64'(HALF));
                    chk("pen_clk_low", 64'(pen_bad), 64'd0);
                    chk("sout_stable", 64'(sout_bad), 64'd0);
                    chk("done_shape", 64'({prev_busy, bus.busy, prev_done}), 64'b100);
`ifdef SEG_AUTO_REFRESH_EN
                    if (seen_done) chk("frame_period", 64'(since_done), 64'(BUSY_LEN + 1));
`endif
                end
                seen_done = 1; since_done = 0;
                edges = 0; busy_cnt = 0; pen_cnt = 0; pen_bad = 0; sout_bad = 0; latched = '0;
            end
            prev_clk = bus.seg_clk; prev_sout = bus.seg_sout; prev_pen = bus.seg_pen;
            prev_busy = bus.busy; prev_done = bus.done;
        end
    end

    // Wait for done while scrambling seg_txt and optionally firing ignored starts
    task automatic wait_done(input bit noisy);
        bit got = 0;
        for (int i = 0; i < 2 * BUSY_LEN; i++) begin
            @(negedge clk);
            if (bus.done) begin got = 1; break; end
            bus.seg_txt = rnd64();
`ifndef SEG_AUTO_REFRESH_EN
            if (noisy) bus.start = ($urandom_range(0, 15) == 0);
`endif
        end
        bus.start = 1'b0;
        if (!got) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_frame(input logic [NBITS-1:0] txt, input bit noisy);
        bus.start   = 1'b1;
        bus.seg_txt = txt;
        exp_q.push_back(txt);
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_next_cycle", 64'(bus.busy), 64'd1);
        wait_done(noisy);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  any;
        logic p;
        bus.start   = 1'b1;
        bus.seg_txt = 64'h8000_0000_0000_0001;
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("reset_outputs", 64'({bus.busy, bus.done, bus.seg_clk, bus.seg_sout,
                                      bus.seg_pen, bus.seg_clrn}), 64'd0);
        end
`ifndef SEG_AUTO_REFRESH_EN
        bus.start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("clrn_after_reset", 64'(bus.seg_clrn), 64'd1);
        chk("idle_after_reset", 64'(bus.busy), 64'd0);

        run_frame(64'h8000_0000_0000_0001, 1'b0);
        repeat (2) @(negedge clk);
        run_frame(64'hC0F9_A4B0_9992_82F8, 1'b0);

        // Ignored mid-frame start, then a new frame issued in the done cycle
        run_frame(rnd64(), 1'b1);
        run_frame(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("no_queued_start", 64'(bus.busy), 64'd0);
        end

        for (int f = 0; f < 4; f++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_frame(rnd64(), 1'b1);
        end

        // Abort a frame after 20 shift-clock edges
        bus.start = 1'b1; bus.seg_txt = rnd64(); exp_q.push_back(bus.seg_txt);
        @(negedge clk);
        bus.start = 1'b0;
        n = 0; p = bus.seg_clk;
        for (int i = 0; i < 1000 && n < 20; i++) begin
            @(negedge clk);
            if (bus.seg_clk && !p) n++;
            p = bus.seg_clk;
        end
        chk("abort_edges_reached", 64'(n), 64'd20);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_outputs", 64'({bus.busy, bus.done, bus.seg_clk, bus.seg_sout,
                                  bus.seg_pen, bus.seg_clrn}), 64'd0);
        rst = 1'b0;
        exp_q.delete();
        any = 0;
        repeat (BUSY_LEN + 10) begin
            @(negedge clk);
            any |= bus.done | bus.seg_pen | bus.busy;
        end
        chk("no_pulse_after_abort", 64'(any), 64'd0);
        run_frame(rnd64(), 1'b1);
`else
        bus.start = 1'b0;
        exp_q.push_back(bus.seg_txt);
        rst = 1'b0;
        @(negedge clk);
        chk("clrn_after_reset", 64'(bus.seg_clrn), 64'd1);
        chk("auto_busy_after_reset", 64'(bus.busy), 64'd1);
        for (int f = 0; f < 6; f++) begin
            wait_done(1'b0);
            bus.seg_txt = (f == 0) ? 64'hC0F9_A4B0_9992_82F8 : rnd64();
            exp_q.push_back(bus.seg_txt);
        end
        wait_done(1'b0);
`endif
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg_serial_shifter.md
Name: seg_serial_shifter

Overview:
- Consumes the 64-bit segment image from the hex-to-segment encoder: 8 digits × 8 bits.
- Shifts the image serially into the board's daisy-chained 74HC595-style segment shift registers, then pulses the parallel-latch line.
- Sits between the segment encoder and the display pins, with one shift engine per display.
- Frames run on a start pulse; the busy/done handshake lets the display controller sequence refreshes.

Parameters:
- NBITS, 64, number of bits per frame (8 digits × 8 segments)
- HALF, 2, half-period of seg_clk in system-clock cycles (≥1)
- CW, 8, width of the bit counter (must hold NBITS)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a frame; sampled only in IDLE
- seg_txt  in  NBITS  segment image; bit NBITS-1 shifted first; captured on the accepting edge
- busy  out  1  high while a frame is in progress
- done  out  1  one-cycle pulse at end of frame
- seg_clk  out  1  shift clock to the external chain; data sampled on its rising edge
- seg_sout  out  1  serial data to the chain
- seg_pen  out  1  active-high parallel latch (RCLK)
- seg_clrn  out  1  active-low clear to the chain

Behaviour:
- Reset: all outputs registered. While rst=1: busy=0, done=0, seg_clk=0, seg_sout=0, seg_pen=0, seg_clrn=0. seg_clrn=1 from the first cycle after rst falls. Shift register, bit counter and divider counter are cleared.
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
- IDLE:
  - start=1 loads seg_txt into the shift register and clears bitcnt and divcnt.
  - seg_sout takes seg_txt[NBITS-1]; busy=1 from the next cycle.
  - Next state is SHIFT_LO.
- SHIFT_LO:
  - seg_clk=0 for HALF cycles, with seg_sout stable.
  - Then go to SHIFT_HI.
- SHIFT_HI:
  - seg_clk=1 for HALF cycles.
  - On leaving, shift left by one and set seg_sout to the new MSB; bitcnt increments.
  - If bitcnt reaches NBITS-1 before incrementing, go to LATCH; otherwise go to SHIFT_LO.
- LATCH:
  - seg_clk=0 and seg_pen=1 for HALF cycles.
  - Then return to IDLE: busy=0, done=1 for exactly one cycle, seg_pen=0, seg_sout=0.
- Timing: busy is high for exactly NBITS·2·HALF + HALF cycles; done follows in the first cycle busy is low. Defaults give 258 busy cycles.
- seg_sout changes only while seg_clk=0 or on the SHIFT_HI→SHIFT_LO edge. It never changes while seg_clk rises.
- start while busy is ignored and not queued. start coincident with the done cycle is accepted, since the block is already in IDLE.
- Changes to seg_txt after capture do not affect the frame in flight.
- rst mid-frame aborts immediately: no latch pulse, no done pulse, reset values next cycle.
- Divider counter wraps at HALF-1. HALF=1 gives seg_clk = clk/2.

Optional Feature:
- Macro: SEG_AUTO_REFRESH_EN.
- Defined: the start port is ignored. After reset, and in the cycle after each done, the block behaves as if start=1, capturing a fresh seg_txt each frame. The frame period is NBITS·2·HALF + HALF + 1 cycles.
- Undefined: frames run only on an explicit start.

Test Plan:
- Reset: hold rst 3 cycles with start=1 → all outputs 0 including seg_clrn; seg_clrn=1 from the first post-reset cycle; no frame begins while rst=1.
- Single frame, seg_txt=64'h8000_0000_0000_0001, start 1 cycle:
  - busy high exactly 258 cycles; 64 seg_clk rising edges.
  - Bits sampled at the edges are 1, 62×0, 1.
  - seg_pen high 2 cycles with seg_clk=0; done single pulse.
- Pattern integrity, seg_txt=64'hC0F9_A4B0_9992_82F8 → a 64-bit model shift register clocked by seg_clk and latched by seg_pen equals the input.
- Busy-ignore and back-to-back: pulse start mid-frame → no effect; assert start in the done cycle with new seg_txt=64'hFFFF_FFFF_FFFF_FFFF → second frame starts with no idle gap and shifts all ones.
- Mid-frame reset: assert rst after 20 seg_clk edges → outputs return to reset values next cycle; no seg_pen or done pulse.
- With SEG_AUTO_REFRESH_EN, start tied 0 → consecutive frames every 259 cycles; each frame latches the current seg_txt.
